// File: rtl/miriscv_mem_resp_stage.sv
// Memory-response stage: waits for the data-memory response of the M instruction,
// extracts/extends load data, picks the writeback value and updates the W register.

package miriscv_pkg;
  parameter int XLEN = 32;
endpackage

package miriscv_gpr_pkg;
  parameter int GPR_ADDR_W = 5;
endpackage

package miriscv_lsu_pkg;
  parameter int MEM_ACCESS_W = 3;
  parameter logic [MEM_ACCESS_W-1:0] MEM_ACCESS_WORD  = 3'd0;
  parameter logic [MEM_ACCESS_W-1:0] MEM_ACCESS_HALF  = 3'd1;
  parameter logic [MEM_ACCESS_W-1:0] MEM_ACCESS_BYTE  = 3'd2;
  parameter logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UHALF = 3'd3;
  parameter logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UBYTE = 3'd4;

  typedef enum logic [1:0] {
    RESP_IDLE  = 2'd0,
    RESP_WAIT  = 2'd1,
    RESP_HOLD  = 2'd2,
    RESP_DRAIN = 2'd3
  } resp_state_e;
endpackage

package miriscv_decode_pkg;
  parameter int WB_SRC_W = 2;
  parameter logic [WB_SRC_W-1:0] ALU_DATA = 2'd0;
  parameter logic [WB_SRC_W-1:0] MDU_DATA = 2'd1;
  parameter logic [WB_SRC_W-1:0] LSU_DATA = 2'd2;
endpackage

module miriscv_mem_resp_stage
  import miriscv_pkg::*;
  import miriscv_gpr_pkg::*;
  import miriscv_lsu_pkg::*;
  import miriscv_decode_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic                    cu_kill_w_i,
  input  logic                    cu_stall_w_i,
  output logic                    w_stall_req_o,
  input  logic                    m_valid_i,
  input  logic                    m_gpr_wr_en_i,
  input  logic [GPR_ADDR_W-1:0]   m_gpr_wr_addr_i,
  input  logic [WB_SRC_W-1:0]     m_gpr_src_sel_i,
  input  logic [XLEN-1:0]         m_alu_result_i,
  input  logic [XLEN-1:0]         m_mdu_result_i,
  input  logic                    m_mem_req_i,
  input  logic                    m_mem_we_i,
  input  logic [MEM_ACCESS_W-1:0] m_mem_size_i,
  input  logic [1:0]              m_mem_addr_i,
  input  logic                    data_rvalid_i,
  input  logic [XLEN-1:0]         data_rdata_i,
  output logic                    w_valid_o,
  output logic                    w_gpr_wr_en_o,
  output logic [GPR_ADDR_W-1:0]   w_gpr_wr_addr_o,
  output logic [XLEN-1:0]         w_gpr_wr_data_o,
  output logic [XLEN-1:0]         w_byp_data_o,
  output resp_state_e             dbg_state_o
);

  resp_state_e     state, state_next;
  logic [XLEN-1:0] rsp_buf;
  logic            buf_load;
  logic            pending;
  logic [XLEN-1:0] rsp_data, rsp_shift, load_data, wb_data;

  // Store responses are only waited for; their data never reaches W.
  logic unused_we;
  assign unused_we = m_mem_we_i;

  assign pending     = m_valid_i & m_mem_req_i;
  assign rsp_data    = (state == RESP_HOLD) ? rsp_buf : data_rdata_i;
  assign rsp_shift   = rsp_data >> {m_mem_addr_i, 3'b000};
  assign dbg_state_o = state;

  always_comb begin
    load_data = rsp_data;
    case (m_mem_size_i)
      MEM_ACCESS_BYTE:  load_data = {{(XLEN-8){rsp_shift[7]}}, rsp_shift[7:0]};
      MEM_ACCESS_UBYTE: load_data = {{(XLEN-8){1'b0}}, rsp_shift[7:0]};
      MEM_ACCESS_HALF:  load_data = {{(XLEN-16){rsp_shift[15]}}, rsp_shift[15:0]};
      MEM_ACCESS_UHALF: load_data = {{(XLEN-16){1'b0}}, rsp_shift[15:0]};
      default:          load_data = rsp_data;
    endcase
  end

  always_comb begin
    wb_data = m_alu_result_i;
    case (m_gpr_src_sel_i)
      MDU_DATA: wb_data = m_mdu_result_i;
      LSU_DATA: wb_data = load_data;
      default:  wb_data = m_alu_result_i;
    endcase
  end

  assign w_byp_data_o = wb_data;

  always_comb begin
    state_next    = state;
    buf_load      = 1'b0;
    w_stall_req_o = 1'b0;
    case (state)
      RESP_IDLE: begin
        w_stall_req_o = pending & ~data_rvalid_i;
        if (pending && !data_rvalid_i) begin
          state_next = RESP_WAIT;
        end else if (pending && cu_stall_w_i && !cu_kill_w_i) begin
          state_next = RESP_HOLD;
          buf_load   = 1'b1;
        end
      end
      RESP_WAIT: begin
        w_stall_req_o = pending & ~data_rvalid_i;
        if (data_rvalid_i) begin
          // A killed instruction consumes its response here instead of draining.
          if (cu_stall_w_i && !cu_kill_w_i) begin
            state_next = RESP_HOLD;
            buf_load   = 1'b1;
          end else begin
            state_next = RESP_IDLE;
          end
        end else if (cu_kill_w_i) begin
          state_next = RESP_DRAIN;
        end
      end
      RESP_HOLD: begin
        if (cu_kill_w_i || !cu_stall_w_i) state_next = RESP_IDLE;
      end
      RESP_DRAIN: begin
        w_stall_req_o = pending;
        if (data_rvalid_i) state_next = RESP_IDLE;
      end
      default: state_next = RESP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state   <= RESP_IDLE;
      rsp_buf <= '0;
    end else begin
      state <= state_next;
      if (buf_load) rsp_buf <= data_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      w_valid_o       <= 1'b0;
      w_gpr_wr_en_o   <= 1'b0;
      w_gpr_wr_addr_o <= '0;
      w_gpr_wr_data_o <= '0;
    end else if (cu_kill_w_i) begin
      w_valid_o <= 1'b0;
    end else if (!cu_stall_w_i && !w_stall_req_o) begin
      w_valid_o <= m_valid_i;
      if (m_valid_i) begin
        w_gpr_wr_en_o   <= m_gpr_wr_en_i;
        w_gpr_wr_addr_o <= m_gpr_wr_addr_i;
        w_gpr_wr_data_o <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_mem_resp_stage.sv
// Bench for miriscv_mem_resp_stage: vector table, directed multi-cycle sequences
// and randomized transactions scored against an arithmetic load model.

module tb_miriscv_mem_resp_stage;
  import miriscv_lsu_pkg::*;
  import miriscv_decode_pkg::*;

  logic        clk_i, arstn_i;
  logic        cu_kill_w_i, cu_stall_w_i, w_stall_req_o;
  logic        m_valid_i, m_gpr_wr_en_i;
  logic [4:0]  m_gpr_wr_addr_i;
  logic [1:0]  m_gpr_src_sel_i;
  logic [31:0] m_alu_result_i, m_mdu_result_i;
  logic        m_mem_req_i, m_mem_we_i;
  logic [2:0]  m_mem_size_i;
  logic [1:0]  m_mem_addr_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        w_valid_o, w_gpr_wr_en_o;
  logic [4:0]  w_gpr_wr_addr_o;
  logic [31:0] w_gpr_wr_data_o, w_byp_data_o;
  resp_state_e dbg_state_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  miriscv_mem_resp_stage dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .cu_kill_w_i(cu_kill_w_i), .cu_stall_w_i(cu_stall_w_i), .w_stall_req_o(w_stall_req_o),
    .m_valid_i(m_valid_i), .m_gpr_wr_en_i(m_gpr_wr_en_i), .m_gpr_wr_addr_i(m_gpr_wr_addr_i),
    .m_gpr_src_sel_i(m_gpr_src_sel_i), .m_alu_result_i(m_alu_result_i),
    .m_mdu_result_i(m_mdu_result_i), .m_mem_req_i(m_mem_req_i), .m_mem_we_i(m_mem_we_i),
    .m_mem_size_i(m_mem_size_i), .m_mem_addr_i(m_mem_addr_i),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .w_valid_o(w_valid_o), .w_gpr_wr_en_o(w_gpr_wr_en_o), .w_gpr_wr_addr_o(w_gpr_wr_addr_o),
    .w_gpr_wr_data_o(w_gpr_wr_data_o), .w_byp_data_o(w_byp_data_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  size;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Load result from plain integer arithmetic: divide out the offset, take a modulus, fold the sign.
  function automatic logic [31:0] ref_load(input logic [2:0] size, input logic [1:0] off,
                                           input logic [31:0] word);
    longint v;
    longint r;
    v = longint'(word) / (64'd1 << (8 * off));
    r = longint'(word);
    case (size)
      MEM_ACCESS_BYTE:  begin r = v % 256;   if (r >= 128)   r = r - 256;   end
      MEM_ACCESS_UBYTE: r = v % 256;
      MEM_ACCESS_HALF:  begin r = v % 65536; if (r >= 32768) r = r - 65536; end
      MEM_ACCESS_UHALF: r = v % 65536;
      default:          r = longint'(word);
    endcase
    return r[31:0];
  endfunction

  // driver tasks
  task automatic idle_inputs();
    cu_kill_w_i = 0; cu_stall_w_i = 0;
    m_valid_i = 0; m_gpr_wr_en_i = 0; m_gpr_wr_addr_i = 0; m_gpr_src_sel_i = ALU_DATA;
    m_alu_result_i = 0; m_mdu_result_i = 0;
    m_mem_req_i = 0; m_mem_we_i = 0; m_mem_size_i = MEM_ACCESS_WORD; m_mem_addr_i = 0;
    data_rvalid_i = 0; data_rdata_i = 0;
  endtask

  task automatic drive_load(input logic [2:0] size, input logic [1:0] off, input logic [4:0] rd);
    m_valid_i = 1; m_gpr_wr_en_i = 1; m_gpr_wr_addr_i = rd; m_gpr_src_sel_i = LSU_DATA;
    m_mem_req_i = 1; m_mem_we_i = 0; m_mem_size_i = size; m_mem_addr_i = off;
    m_alu_result_i = $urandom; m_mdu_result_i = $urandom;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that writes W.
  task automatic run_txn(input logic is_mem, input logic [2:0] size, input logic [1:0] off,
                         input logic [31:0] rdata, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] mdu, input logic [4:0] rd,
                         input int delay, input int stall_cyc, input logic [31:0] expv,
                         input string tag);
    exp_q.push_back(expv);
    m_valid_i = 1; m_gpr_wr_en_i = 1; m_gpr_wr_addr_i = rd; m_gpr_src_sel_i = src;
    m_alu_result_i = alu; m_mdu_result_i = mdu;
    m_mem_req_i = is_mem; m_mem_we_i = 0; m_mem_size_i = size; m_mem_addr_i = off;
    cu_stall_w_i = 0; data_rvalid_i = 0; data_rdata_i = $urandom;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk_i);
      check({tag, " stall_while_waiting"}, 32'(w_stall_req_o), 32'd1);
      @(posedge clk_i); #1;
    end
    data_rvalid_i = is_mem; data_rdata_i = rdata; cu_stall_w_i = (stall_cyc > 0);
    @(negedge clk_i);
    check({tag, " stall_on_response"}, 32'(w_stall_req_o), 32'd0);
    check({tag, " byp"}, w_byp_data_o, expv);
    for (int i = 0; i < stall_cyc; i++) begin
      @(posedge clk_i); #1;
      data_rvalid_i = 0; data_rdata_i = $urandom; cu_stall_w_i = (i < stall_cyc - 1);
      @(negedge clk_i);
      check({tag, " hold_byp"}, w_byp_data_o, expv);
    end
    @(posedge clk_i); #1;
    check({tag, " w_valid"}, 32'(w_valid_o), 32'd1);
    check({tag, " w_wr_en"}, 32'(w_gpr_wr_en_o), 32'd1);
    check({tag, " w_addr"}, 32'(w_gpr_wr_addr_o), 32'(rd));
    check({tag, " w_data"}, w_gpr_wr_data_o, exp_q.pop_front());
    idle_inputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " w_valid"}, 32'(w_valid_o), 32'd0);
    check({tag, " w_wr_en"}, 32'(w_gpr_wr_en_o), 32'd0);
    check({tag, " w_addr"}, 32'(w_gpr_wr_addr_o), 32'd0);
    check({tag, " w_data"}, w_gpr_wr_data_o, 32'd0);
    check({tag, " state"}, 32'(dbg_state_o), 32'(RESP_IDLE));
  endtask

  initial begin
    vecs[0] = '{MEM_ACCESS_UBYTE, 2'd2, 32'h12F45678, 32'h000000F4};
    vecs[1] = '{MEM_ACCESS_BYTE,  2'd2, 32'h12F45678, 32'hFFFFFFF4};
    vecs[2] = '{MEM_ACCESS_BYTE,  2'd0, 32'h12F45678, 32'h00000078};
    vecs[3] = '{MEM_ACCESS_HALF,  2'd2, 32'h80010000, 32'hFFFF8001};
    vecs[4] = '{MEM_ACCESS_UHALF, 2'd2, 32'h80010000, 32'h00008001};
    vecs[5] = '{MEM_ACCESS_HALF,  2'd3, 32'h80FF0000, 32'h00000080};
    vecs[6] = '{MEM_ACCESS_HALF,  2'd0, 32'h00008000, 32'hFFFF8000};
    vecs[7] = '{MEM_ACCESS_WORD,  2'd0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[8] = '{MEM_ACCESS_BYTE,  2'd3, 32'h80000000, 32'hFFFFFF80};
    vecs[9] = '{MEM_ACCESS_UHALF, 2'd1, 32'hAB12CD00, 32'h000012CD};

    idle_inputs();
    arstn_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    check("reset stall_req", 32'(w_stall_req_o), 32'd0);
    arstn_i = 1;
    @(posedge clk_i); #1;

    // zero-wait vector table
    foreach (vecs[i])
      run_txn(1'b1, vecs[i].size, vecs[i].off, vecs[i].rdata, LSU_DATA, 32'h0, 32'h0,
              5'(i + 1), 0, 0, vecs[i].exp, $sformatf("vec%0d", i));

    // delayed halfword load
    run_txn(1'b1, MEM_ACCESS_HALF, 2'd2, 32'h80010000, LSU_DATA, 32'h0, 32'h0, 5'd7, 3, 0,
            32'hFFFF8001, "lh_delay3");
    // word arriving under a 2-cycle W stall
    run_txn(1'b1, MEM_ACCESS_WORD, 2'd0, 32'hCAFE0123, LSU_DATA, 32'h0, 32'h0, 5'd8, 1, 2,
            32'hCAFE0123, "lw_stall2");
    // ALU then MDU back-to-back
    run_txn(1'b0, MEM_ACCESS_WORD, 2'd0, 32'h0, ALU_DATA, 32'h55, 32'h99, 5'd9, 0, 0,
            32'h55, "alu");
    run_txn(1'b0, MEM_ACCESS_WORD, 2'd0, 32'h0, MDU_DATA, 32'h77, 32'hAA, 5'd10, 0, 0,
            32'hAA, "mdu");

    // kill and response in the same cycle: consumed, no write, back to IDLE
    drive_load(MEM_ACCESS_WORD, 2'd0, 5'd11);
    data_rvalid_i = 1; data_rdata_i = 32'h13579BDF; cu_kill_w_i = 1;
    @(posedge clk_i); #1;
    check("kill_rsp w_valid", 32'(w_valid_o), 32'd0);
    check("kill_rsp state", 32'(dbg_state_o), 32'(RESP_IDLE));
    idle_inputs();

    // kill in WAIT, new LW before the old response
    drive_load(MEM_ACCESS_WORD, 2'd0, 5'd12);
    @(posedge clk_i); #1;
    check("killwait state_wait", 32'(dbg_state_o), 32'(RESP_WAIT));
    cu_kill_w_i = 1;
    @(negedge clk_i);
    check("killwait stall_kill", 32'(w_stall_req_o), 32'd1);
    @(posedge clk_i); #1;
    check("killwait state_drain", 32'(dbg_state_o), 32'(RESP_DRAIN));
    check("killwait w_valid", 32'(w_valid_o), 32'd0);
    cu_kill_w_i = 0;
    drive_load(MEM_ACCESS_WORD, 2'd0, 5'd13);
    @(negedge clk_i);
    check("killwait stall_drain", 32'(w_stall_req_o), 32'd1);
    @(posedge clk_i); #1;
    data_rvalid_i = 1; data_rdata_i = 32'h11111111;
    @(negedge clk_i);
    check("killwait stall_discard", 32'(w_stall_req_o), 32'd1);
    @(posedge clk_i); #1;
    check("killwait w_valid_discard", 32'(w_valid_o), 32'd0);
    data_rvalid_i = 0;
    @(negedge clk_i);
    check("killwait stall_after", 32'(w_stall_req_o), 32'd1);
    @(posedge clk_i); #1;
    data_rvalid_i = 1; data_rdata_i = 32'h22222222;
    @(negedge clk_i);
    check("killwait stall_rsp", 32'(w_stall_req_o), 32'd0);
    @(posedge clk_i); #1;
    check("killwait w_valid_new", 32'(w_valid_o), 32'd1);
    check("killwait w_addr_new", 32'(w_gpr_wr_addr_o), 32'd13);
    check("killwait w_data_new", w_gpr_wr_data_o, 32'h22222222);
    idle_inputs();

    // reset in WAIT, then a stray response
    drive_load(MEM_ACCESS_WORD, 2'd0, 5'd14);
    @(posedge clk_i); #1;
    check("rstwait state_wait", 32'(dbg_state_o), 32'(RESP_WAIT));
    arstn_i = 0;
    #1;
    check_reset_outputs("rstwait");
    idle_inputs();
    @(posedge clk_i); #1;
    arstn_i = 1;
    data_rvalid_i = 1; data_rdata_i = 32'hBADBAD00;
    @(negedge clk_i);
    check("stray stall_req", 32'(w_stall_req_o), 32'd0);
    @(posedge clk_i); #1;
    check("stray w_valid", 32'(w_valid_o), 32'd0);
    check("stray state", 32'(dbg_state_o), 32'(RESP_IDLE));
    idle_inputs();

    // randomized transactions against the reference model
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  sz;
      logic [1:0]  off, src;
      logic [31:0] rd_word, alu, mdu, expv;
      logic [4:0]  rd;
      sz = 3'($urandom_range(0, 4));
      off = 2'($urandom_range(0, 3));
      rd_word = $urandom; alu = $urandom; mdu = $urandom;
      rd = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 3) != 0) begin
        run_txn(1'b1, sz, off, rd_word, LSU_DATA, alu, mdu, rd,
                $urandom_range(0, 3), $urandom_range(0, 2), ref_load(sz, off, rd_word),
                $sformatf("rnd%0d_ld", n));
      end else begin
        case ($urandom_range(0, 2))
          0:       begin src = ALU_DATA; expv = alu; end
          1:       begin src = MDU_DATA; expv = mdu; end
          default: begin src = 2'd3;     expv = alu; end
        endcase
        run_txn(1'b0, MEM_ACCESS_WORD, 2'd0, 32'h0, src, alu, mdu, rd, 0, 0, expv,
                $sformatf("rnd%0d_op", n));
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i); #1;
        check($sformatf("rnd%0d_bubble w_valid", n), 32'(w_valid_o), 32'd0);
      end
    end

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/miriscv_mem_resp_stage.md
# miriscv_mem_resp_stage

Memory-response stage of the miriscv pipeline, directly downstream of the memory-request stage. It collects the data-memory response for the instruction in M, aligns and sign/zero-extends load data, selects the writeback value among ALU, MDU and LSU results, and registers it into the writeback (W) pipeline register. It raises a stall request while a response is outstanding, holds a response that arrives during a W stall, and discards responses of killed instructions.

## Interface
- XLEN, 32 (from miriscv_pkg): data width.
- GPR_ADDR_W, MEM_ACCESS_W, WB_SRC_W: from miriscv_gpr_pkg, miriscv_lsu_pkg and miriscv_decode_pkg.
- clk_i  in  1  clock; one clock domain.
- arstn_i  in  1  asynchronous, active-low reset.
- cu_kill_w_i  in  1  kill the M instruction and do not write it to W.
- cu_stall_w_i  in  1  hold the W register.
- w_stall_req_o  out  1  this stage needs the pipeline held.
- m_valid_i  in  1  M instruction valid.
- m_gpr_wr_en_i, m_gpr_wr_addr_i, m_gpr_src_sel_i  in  1/GPR_ADDR_W/WB_SRC_W  destination register info.
- m_alu_result_i, m_mdu_result_i  in  XLEN  execute results.
- m_mem_req_i, m_mem_we_i  in  1  instruction issued a memory access / the access is a store.
- m_mem_size_i  in  MEM_ACCESS_W  MEM_ACCESS_* encoding.
- m_mem_addr_i  in  2  byte offset of the access.
- data_rvalid_i  in  1  data-memory response valid.
- data_rdata_i  in  XLEN  response data.
- w_valid_o  out  1  W instruction valid.
- w_gpr_wr_en_o, w_gpr_wr_addr_o  out  1/GPR_ADDR_W  registered register-write controls.
- w_gpr_wr_data_o  out  XLEN  registered writeback data.
- w_byp_data_o  out  XLEN  combinational writeback value of the M instruction, used for forwarding.

## Operation
- A memory access is pending when m_valid_i & m_mem_req_i.
- Response source: the buffer in HOLD; otherwise data_rdata_i when data_rvalid_i is high.
- Load extraction: shift the response right by 8·m_mem_addr_i.
  - MEM_ACCESS_BYTE / UBYTE: sign- / zero-extend bits [7:0].
  - MEM_ACCESS_HALF / UHALF: sign- / zero-extend bits [15:0]. At offset 3 the missing upper byte reads as 0 before extension.
  - MEM_ACCESS_WORD: the full word.
- Writeback select: ALU_DATA → alu; MDU_DATA → mdu; LSU_DATA → extracted load; any other value → alu.
- Stores wait for their response like loads. Their data is not used.

The state machine has four states:
- IDLE
  - Pending with no response → WAIT.
  - Pending, response arrives and cu_stall_w_i is high → capture into the buffer, go to HOLD.
  - Otherwise stay in IDLE.
- WAIT
  - Response arrives and cu_stall_w_i is high → HOLD.
  - Response arrives with no stall → IDLE.
  - cu_kill_w_i with no response → DRAIN.
- HOLD
  - cu_stall_w_i low → W register loads, go to IDLE.
  - cu_kill_w_i → IDLE, buffer dropped.
- DRAIN
  - The next data_rvalid_i is discarded, then go to IDLE.
  - A new pending instruction is not served by that discarded response.

w_stall_req_o is combinational:
- IDLE / WAIT: pending & ~data_rvalid_i.
- HOLD: 0.
- DRAIN: equal to pending.

## Timing
- W register update:
  - Kill has priority: w_valid_o ← 0.
  - Otherwise, when ~cu_stall_w_i & ~w_stall_req_o, w_valid_o ← m_valid_i.
  - Data fields load only when m_valid_i is also high.
- Reset: every output register is 0; state is IDLE; the buffer is 0.
- Zero-wait response (data_rvalid_i in the same cycle the instruction sits in M): no stall, and W is written at the next edge.
- Each cycle without a response adds one cycle of latency.
- w_byp_data_o has zero latency and is valid for a load only in a cycle where the response is available.
- Kill and response in the same cycle in WAIT/IDLE: the response is consumed, W is not written, next state is IDLE (not DRAIN).
- Reset mid-access returns to IDLE immediately. A later stray data_rvalid_i with no pending access is ignored.

## Test plan
- Zero-wait LBU, addr offset 2, rdata 0x12F45678 → w_gpr_wr_data_o = 0x000000F4 one cycle later, w_stall_req_o never high.
- LH offset 2, rdata 0x80010000, response delayed 3 cycles → w_stall_req_o high 3 cycles, then data 0xFFFF8001.
- LW with response arriving while cu_stall_w_i is high for 2 cycles, and rdata changing afterwards → the buffered word is written when the stall drops.
- Kill in WAIT, then a new LW pending before the old response → the first rvalid is discarded, the second rvalid value is written, w_stall_req_o stays high throughout.
- ALU instruction with result 0x55 and MDU_DATA instruction with mdu result 0xAA back-to-back → W gets 0x55 then 0xAA.
- Reset asserted in WAIT → all outputs 0, state IDLE, and a stray rvalid afterwards produces no write.
